fsquare_iter: RTL and testbench



---
 rtl/fsquare_iter_if.sv | 17 +
 rtl/fsquare_iter.sv | 162 ++++++++++++++++
 tb/tb_fsquare_iter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsquare_iter_if.sv
// rtl/fsquare_iter_if.sv - operand/result handshake bundle for the iterative squarer
interface fsquare_iter_if #(
  parameter int WE = 5,
  parameter int WF = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WE+WF+2:0]      X;
  logic                  out_valid;
  logic                  out_ready;
  logic [WE+WF+2:0]      R;

  modport master (output in_valid, output X, output out_ready,
                  input  in_ready, input  out_valid, input  R);
  modport slave  (input  in_valid, input  X, input  out_ready,
                  output in_ready, output out_valid, output R);
endinterface

// File: rtl/fsquare_iter.sv
// rtl/fsquare_iter.sv - shift-add FloPoCo squarer R = X*X, constant WF+3 edge latency
// Optional ovf/unf flag outputs under FSQUARE_ITER_FLAGS_EN.
module fsquare_iter #(
  parameter int WE = 5,
  parameter int WF = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fsquare_iter_if.slave   bus
`ifdef FSQUARE_ITER_FLAGS_EN
  ,
  output logic            ovf,
  output logic            unf
`endif
);
  localparam int W    = WE + WF + 3;
  localparam int AW   = 2 * (WF + 1);
  localparam int EW   = WE + 2;
  localparam int CW   = $clog2(WF + 1);
  localparam int BIAS = 2 ** (WE - 1) - 1;

  typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

  state_t          state_q;
  logic [WF:0]     m_q;
  logic [WE-1:0]   e_q;
  logic [1:0]      exc_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    r_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            ovf_q;
  logic            unf_q;

  logic [AW-1:0]   acc_d;
  logic            norm;
  logic [WF-1:0]   frac;
  logic            guard;
  logic            sticky;
  logic [WF:0]     frac_rnd;
  logic            carry;
  logic [EW-1:0]   er;
  logic            er_neg;
  logic            er_big;
  logic [W-1:0]    r_d;
  logic            ovf_d;
  logic            unf_d;
  logic            unused_sign;

  assign unused_sign = bus.X[WE+WF];

  always_comb begin
    acc_d = acc_q;
    if (m_q[cnt_q])
      acc_d = acc_q + (AW'(m_q) << cnt_q);
  end

  // Product lies in [1,4): the top accumulator bit selects the normalisation.
  always_comb begin
    norm = acc_q[AW-1];
    if (norm) begin
      frac   = acc_q[2*WF -: WF];
      guard  = acc_q[WF];
      sticky = |acc_q[WF-1:0];
    end else begin
      frac   = acc_q[2*WF-1 -: WF];
      guard  = acc_q[WF-1];
      sticky = |acc_q[WF-2:0];
    end
    frac_rnd = {1'b0, frac} + (WF+1)'(guard & (sticky | frac[0]));
    carry    = frac_rnd[WF];
    er       = {1'b0, e_q, 1'b0} - EW'(BIAS) + EW'(norm) + EW'(carry);
    er_neg   = er[EW-1];
    er_big   = !er[EW-1] && er[EW-2];
  end

  always_comb begin
    r_d   = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    case (exc_q)
      2'b01: begin
        if (er_neg) begin
          unf_d = 1'b1;
        end else if (er_big) begin
          r_d   = {2'b10, {(W-2){1'b0}}};
          ovf_d = 1'b1;
        end else begin
          r_d = {2'b01, 1'b0, er[WE-1:0], frac_rnd[WF-1:0]};
        end
      end
      2'b10:   r_d = {2'b10, {(W-2){1'b0}}};
      2'b11:   r_d = {2'b11, {(W-2){1'b0}}};
      default: r_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      exc_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            m_q        <= {1'b1, bus.X[WF-1:0]};
            e_q        <= bus.X[WF+WE-1:WF];
            exc_q      <= bus.X[W-1:W-2];
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WF))
            state_q <= RND;
        end
        RND: begin
          r_q         <= r_d;
          ovf_q       <= ovf_d;
          unf_q       <= unf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;

`ifdef FSQUARE_ITER_FLAGS_EN
  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_q ^ unf_q;
`endif
endmodule

// File: tb/tb_fsquare_iter.sv
// tb/tb_fsquare_iter.sv - randomized and directed bench for fsquare_iter against an arithmetic model
module tb_fsquare_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fsquare_iter_if #(.WE(5), .WF(4)) bus();
`ifdef FSQUARE_ITER_FLAGS_EN
  logic ovf, unf;
`endif

  fsquare_iter #(.WE(5), .WF(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FSQUARE_ITER_FLAGS_EN
    ,
    .ovf   (ovf),
    .unf   (unf)
`endif
  );

  // Returns {ovf, unf, R}: exact integer square of the significand, then round-to-nearest-even.
  function automatic logic [13:0] model(input logic [11:0] x);
    int m, p, e, sh, q, rem, half, norm, carry, er;
    case (x[11:10])
      2'b00: return 14'h000;
      2'b10: return 14'h800;
      2'b11: return 14'hC00;
      default: ;
    endcase
    m = 16 + int'(x[3:0]);
    p = m * m;
    e = int'(x[8:4]);
    norm = (p >= 512) ? 1 : 0;
    sh = norm ? 5 : 4;
    q = p >> sh;
    rem = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    carry = 0;
    if (q == 32) begin
      carry = 1;
      q = 16;
    end
    er = 2 * e - 15 + norm + carry;
    if (er > 31) return {2'b10, 12'h800};
    if (er < 0)  return {2'b01, 12'h000};
    return {2'b00, 12'h400 | 12'(er << 4) | 12'(q - 16)};
  endfunction

  task automatic run_op(input logic [11:0] x, output logic [11:0] r, output int lat,
                        output logic fo, output logic fu);
    int n;
    n = 0;
    while (!bus.in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    bus.X = x;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.X = 12'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    r = bus.R;
`ifdef FSQUARE_ITER_FLAGS_EN
    fo = ovf; fu = unf;
`else
    fo = 1'b0; fu = 1'b0;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.X = 12'h4F8;
    bus.out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.R !== 12'h000) begin failures++; $display("FAIL reset_R got=%h exp=000", bus.R); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [11:0] xs [9] = '{12'h4F0, 12'h4F8, 12'h6F8, 12'h4FB, 12'h5E0, 12'h410, 12'h000, 12'hA00, 12'hE05};
    logic [11:0] rs [9] = '{12'h4F0, 12'h502, 12'h502, 12'h507, 12'h800, 12'h000, 12'h000, 12'h800, 12'hC00};
    logic        os [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        us [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [11:0] r;
    int lat;
    logic fo, fu;
    for (int i = 0; i < 9; i++) begin
      run_op(xs[i], r, lat, fo, fu);
      checks++; if (r !== rs[i]) begin failures++; $display("FAIL directed_R x=%h got=%h exp=%h", xs[i], r, rs[i]); end
      checks++; if (lat != 7) begin failures++; $display("FAIL directed_latency x=%h got=%0d exp=7", xs[i], lat); end
`ifdef FSQUARE_ITER_FLAGS_EN
      checks++; if (fo !== os[i] || fu !== us[i]) begin failures++; $display("FAIL directed_flags x=%h got=%b%b exp=%b%b", xs[i], fo, fu, os[i], us[i]); end
`else
      if (os[i] || us[i] || fo || fu) ;
`endif
    end
  endtask

  task automatic test_random();
    logic [11:0] x, r;
    logic [13:0] exp_v;
    int lat;
    logic fo, fu;
    for (int i = 0; i < 60; i++) begin
      x = 12'($urandom);
      if ($urandom_range(0, 3) != 0) x[11:10] = 2'b01;
      exp_v = model(x);
      run_op(x, r, lat, fo, fu);
      checks++; if (r !== exp_v[11:0] || lat != 7) begin failures++; $display("FAIL random x=%h got=%h lat=%0d exp=%h lat=7", x, r, lat, exp_v[11:0]); end
`ifdef FSQUARE_ITER_FLAGS_EN
      checks++; if ({fo, fu} !== exp_v[13:12]) begin failures++; $display("FAIL random_flags x=%h got=%b%b exp=%b", x, fo, fu, exp_v[13:12]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] held, r;
    logic [13:0] exp2;
    int lat, bad;
    bus.X = 12'h4FB;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    held = bus.R;
    checks++; if (held !== 12'h507) begin failures++; $display("FAIL bp_first_R got=%h exp=507", held); end
    bus.X = 12'h4F8;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.R !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept in_ready=%b exp=0", bus.in_ready); end
    lat = 1;
    while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    exp2 = model(12'h4F8);
    checks++; if (bus.R !== exp2[11:0] || lat != 7) begin failures++; $display("FAIL bp_second_R got=%h lat=%0d exp=%h lat=7", bus.R, lat, exp2[11:0]); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    bus.X = 12'h4F8;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    bus.in_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    bus.out_ready = 1'b0;
    checks++; if (pulses != 5) begin failures++; $display("FAIL b2b_throughput got=%0d exp=5", pulses); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.X = 12'h4FB;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.R !== 12'h000) begin
      failures++; $display("FAIL midreset got=%b%b R=%h exp=10 R=000", bus.in_ready, bus.out_valid, bus.R); end
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_output got=%0d exp=0", seen); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.X = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
